// File: rtl/tcdm_bank_ctrl.sv
// TCDM bank controller: drives one single-port SRAM and returns ID-tagged responses.
// The set-store phase of a test-and-set bypasses the bank stall and is never answered.
module tcdm_bank_ctrl #(
    parameter int unsigned ADDR_MEM_WIDTH = 12,
    parameter int unsigned ID_WIDTH       = 20,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned AUX_WIDTH      = 2,
    parameter int unsigned BE_WIDTH       = DATA_WIDTH/8,
    parameter int unsigned MEM_LATENCY    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      data_req_i,
    input  logic                      data_ts_set_i,
    input  logic [ADDR_MEM_WIDTH-1:0] data_add_i,
    input  logic                      data_wen_i,
    input  logic [DATA_WIDTH-1:0]     data_wdata_i,
    input  logic [BE_WIDTH-1:0]       data_be_i,
    input  logic [ID_WIDTH-1:0]       data_ID_i,
    input  logic [AUX_WIDTH-1:0]      data_aux_i,
    output logic                      data_gnt_o,
    input  logic                      bank_stall_i,
    output logic                      mem_cen_o,
    output logic                      mem_wen_o,
    output logic [ADDR_MEM_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [DATA_WIDTH-1:0]     mem_bwen_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    output logic                      r_valid_o,
    output logic [ID_WIDTH-1:0]       r_ID_o,
    output logic [AUX_WIDTH-1:0]      r_aux_o,
    output logic [DATA_WIDTH-1:0]     r_rdata_o
);

    if (MEM_LATENCY != 1 && MEM_LATENCY != 2) begin : g_bad_latency
        $error("tcdm_bank_ctrl: MEM_LATENCY must be 1 or 2");
    end

    localparam int unsigned LAST = MEM_LATENCY - 1;

    logic fire;

    logic [MEM_LATENCY-1:0]                vld_q, vld_d;
    logic [MEM_LATENCY-1:0]                load_q, load_d;
    logic [MEM_LATENCY-1:0][ID_WIDTH-1:0]  id_q, id_d;
    logic [MEM_LATENCY-1:0][AUX_WIDTH-1:0] aux_q, aux_d;

    // Stall never blocks the set phase, so the set store lands right after its test read.
    assign data_gnt_o = data_req_i & (~bank_stall_i | data_ts_set_i);
    assign fire       = data_gnt_o;

    assign mem_cen_o   = ~fire;
    assign mem_wen_o   = ~(fire & ~data_wen_i);
    assign mem_addr_o  = data_add_i;
    assign mem_wdata_o = data_wdata_i;

    always_comb begin
        mem_bwen_o = '1;
        if (!data_wen_i) begin
            for (int unsigned i = 0; i < BE_WIDTH; i++) begin
                mem_bwen_o[8*i +: 8] = {8{~data_be_i[i]}};
            end
        end
    end

    always_comb begin
        vld_d     = vld_q;
        load_d    = load_q;
        id_d      = id_q;
        aux_d     = aux_q;
        vld_d[0]  = fire & ~data_ts_set_i;
        load_d[0] = data_wen_i;
        id_d[0]   = data_ID_i;
        aux_d[0]  = data_aux_i;
        for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            load_d[i] = load_q[i-1];
            id_d[i]   = id_q[i-1];
            aux_d[i]  = aux_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            load_q <= '0;
            id_q   <= '0;
            aux_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            load_q <= load_d;
            id_q   <= id_d;
            aux_q  <= aux_d;
        end
    end

    assign r_valid_o = vld_q[LAST];
    assign r_ID_o    = vld_q[LAST] ? id_q[LAST] : '0;
    assign r_aux_o   = vld_q[LAST] ? aux_q[LAST] : '0;
    assign r_rdata_o = (vld_q[LAST] & load_q[LAST]) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_tcdm_bank_ctrl.sv
// Directed bench for tcdm_bank_ctrl: one instance per legal MEM_LATENCY,
// each with its own behavioural SRAM, driven by shared request inputs.
module tb_tcdm_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, ts, wen, stall;
    logic [11:0] add;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [19:0] id;
    logic [1:0]  aux;

    logic        gnt1, cen1, mwen1, vld1;
    logic [11:0] maddr1;
    logic [31:0] mwd1, bwen1, rd1, rdat1;
    logic [19:0] rid1;
    logic [1:0]  raux1;

    logic        gnt2, cen2, mwen2, vld2;
    logic [11:0] maddr2;
    logic [31:0] mwd2, bwen2, rd2, rd2a, rdat2;
    logic [19:0] rid2;
    logic [1:0]  raux2;

    logic [31:0] mem1 [0:4095];
    logic [31:0] mem2 [0:4095];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tcdm_bank_ctrl #(.MEM_LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(req), .data_ts_set_i(ts), .data_add_i(add),
        .data_wen_i(wen), .data_wdata_i(wdata), .data_be_i(be),
        .data_ID_i(id), .data_aux_i(aux), .data_gnt_o(gnt1),
        .bank_stall_i(stall),
        .mem_cen_o(cen1), .mem_wen_o(mwen1), .mem_addr_o(maddr1),
        .mem_wdata_o(mwd1), .mem_bwen_o(bwen1), .mem_rdata_i(rd1),
        .r_valid_o(vld1), .r_ID_o(rid1), .r_aux_o(raux1), .r_rdata_o(rdat1)
    );

    tcdm_bank_ctrl #(.MEM_LATENCY(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(req), .data_ts_set_i(ts), .data_add_i(add),
        .data_wen_i(wen), .data_wdata_i(wdata), .data_be_i(be),
        .data_ID_i(id), .data_aux_i(aux), .data_gnt_o(gnt2),
        .bank_stall_i(stall),
        .mem_cen_o(cen2), .mem_wen_o(mwen2), .mem_addr_o(maddr2),
        .mem_wdata_o(mwd2), .mem_bwen_o(bwen2), .mem_rdata_i(rd2),
        .r_valid_o(vld2), .r_ID_o(rid2), .r_aux_o(raux2), .r_rdata_o(rdat2)
    );

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4096; i++) mem1[i] <= '0;
            rd1 <= '0;
        end else if (!cen1) begin
            if (!mwen1) mem1[maddr1] <= (mem1[maddr1] & bwen1) | (mwd1 & ~bwen1);
            else rd1 <= mem1[maddr1];
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4096; i++) mem2[i] <= '0;
            rd2a <= '0;
            rd2  <= '0;
        end else begin
            rd2 <= rd2a;
            if (!cen2) begin
                if (!mwen2) mem2[maddr2] <= (mem2[maddr2] & bwen2) | (mwd2 & ~bwen2);
                else rd2a <= mem2[maddr2];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic t, input logic [11:0] a,
                         input logic w, input logic [31:0] d, input logic [3:0] b,
                         input logic [19:0] i);
        req = r; ts = t; add = a; wen = w; wdata = d; be = b; id = i; aux = i[1:0];
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 12'h0, 1'b1, 32'h0, 4'h0, 20'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        idle();
        repeat (3) nxt();
        chk("rst_vld1", vld1, 1'b0);
        chk("rst_id1", rid1, 20'h0);
        chk("rst_rdata1", rdat1, 32'h0);
        chk("rst_vld2", vld2, 1'b0);
        chk("rst_aux2", raux2, 2'h0);
        chk("rst_cen1", cen1, 1'b1);
        rst_n = 1'b1;
        nxt();

        // full store then load
        drive(1'b1, 1'b0, 12'h010, 1'b0, 32'hDEADBEEF, 4'hF, 20'd5);
        #1;
        chk("st_gnt", gnt1, 1'b1);
        chk("st_cen", cen1, 1'b0);
        chk("st_wen", mwen1, 1'b0);
        chk("st_bwen", bwen1, 32'h0);
        nxt();
        chk("st_vld1", vld1, 1'b1);
        chk("st_id1", rid1, 20'd5);
        chk("st_aux1", raux1, 2'd1);
        chk("st_rdata1", rdat1, 32'h0);
        chk("st_vld2_early", vld2, 1'b0);
        drive(1'b1, 1'b0, 12'h010, 1'b1, 32'h0, 4'hF, 20'd7);
        #1;
        chk("ld_wen", mwen1, 1'b1);
        chk("ld_bwen", bwen1, 32'hFFFFFFFF);
        nxt();
        chk("ld_vld1", vld1, 1'b1);
        chk("ld_id1", rid1, 20'd7);
        chk("ld_rdata1", rdat1, 32'hDEADBEEF);
        chk("st_id2", rid2, 20'd5);
        chk("st_rdata2", rdat2, 32'h0);
        idle();
        nxt();
        chk("ld_vld1_off", vld1, 1'b0);
        chk("ld_id1_off", rid1, 20'h0);
        chk("ld_id2", rid2, 20'd7);
        chk("ld_rdata2", rdat2, 32'hDEADBEEF);

        // partial write merges bytes 0 and 2
        drive(1'b1, 1'b0, 12'h010, 1'b0, 32'h11223344, 4'b0101, 20'd9);
        #1;
        chk("pw_bwen", bwen1, 32'hFF00FF00);
        chk("pw_wen", mwen1, 1'b0);
        nxt();
        drive(1'b1, 1'b0, 12'h010, 1'b1, 32'h0, 4'hF, 20'd10);
        nxt();
        chk("pw_id1", rid1, 20'd10);
        chk("pw_rdata1", rdat1, 32'hDE22BE44);
        idle();
        nxt();
        chk("pw_rdata2", rdat2, 32'hDE22BE44);

        // test-and-set on a zero location
        drive(1'b1, 1'b0, 12'h020, 1'b1, 32'h0, 4'hF, 20'd3);
        nxt();
        chk("ts_vld1", vld1, 1'b1);
        chk("ts_rdata1", rdat1, 32'h0);
        drive(1'b1, 1'b1, 12'h020, 1'b0, 32'hFFFFFFFF, 4'hF, 20'd3);
        #1;
        chk("ts_set_gnt", gnt2, 1'b1);
        chk("ts_set_cen", cen2, 1'b0);
        chk("ts_set_wen", mwen2, 1'b0);
        chk("ts_set_wdata", mwd2, 32'hFFFFFFFF);
        nxt();
        chk("ts_vld2", vld2, 1'b1);
        chk("ts_id2", rid2, 20'd3);
        chk("ts_rdata2", rdat2, 32'h0);
        chk("ts_set_noresp1", vld1, 1'b0);
        idle();
        nxt();
        chk("ts_set_noresp2", vld2, 1'b0);
        drive(1'b1, 1'b0, 12'h020, 1'b1, 32'h0, 4'hF, 20'd4);
        nxt();
        chk("ts_after1", rdat1, 32'hFFFFFFFF);
        idle();
        nxt();
        chk("ts_after2", rdat2, 32'hFFFFFFFF);

        // load held through a three-cycle stall
        stall = 1'b1;
        drive(1'b1, 1'b0, 12'h010, 1'b1, 32'h0, 4'hF, 20'd11);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_gnt", gnt1, 1'b0);
            chk("stall_cen", cen1, 1'b1);
            nxt();
            chk("stall_vld1", vld1, 1'b0);
        end
        stall = 1'b0;
        #1;
        chk("unstall_gnt", gnt1, 1'b1);
        nxt();
        chk("unstall_vld1", vld1, 1'b1);
        chk("unstall_id1", rid1, 20'd11);
        chk("unstall_rdata1", rdat1, 32'hDE22BE44);
        chk("unstall_vld2_early", vld2, 1'b0);
        idle();
        nxt();
        chk("unstall_id2", rid2, 20'd11);

        // set phase granted while stalled
        stall = 1'b1;
        drive(1'b1, 1'b1, 12'h030, 1'b0, 32'hFFFFFFFF, 4'hF, 20'd12);
        #1;
        chk("sset_gnt", gnt1, 1'b1);
        chk("sset_cen", cen1, 1'b0);
        chk("sset_wen", mwen1, 1'b0);
        nxt();
        chk("sset_noresp1", vld1, 1'b0);
        stall = 1'b0;
        drive(1'b1, 1'b0, 12'h030, 1'b1, 32'h0, 4'hF, 20'd13);
        nxt();
        chk("sset_noresp2", vld2, 1'b0);
        chk("sset_rd1", rdat1, 32'hFFFFFFFF);
        idle();
        nxt();
        chk("sset_rd2", rdat2, 32'hFFFFFFFF);

        // eight back-to-back loads
        for (int i = 0; i < 8; i++) begin
            nxt();
            if (i >= 1) begin
                chk("b2b_vld1", vld1, 1'b1);
                chk("b2b_id1", rid1, 20'(i - 1));
            end
            if (i >= 2) begin
                chk("b2b_vld2", vld2, 1'b1);
                chk("b2b_id2", rid2, 20'(i - 2));
            end
            drive(1'b1, 1'b0, 12'(12'h040 + i), 1'b1, 32'h0, 4'hF, 20'(i));
        end
        nxt();
        chk("b2b_last1", rid1, 20'd7);
        chk("b2b_prev2", rid2, 20'd6);
        idle();
        nxt();
        chk("b2b_end1", vld1, 1'b0);
        chk("b2b_last2", rid2, 20'd7);
        nxt();
        chk("b2b_end2", vld2, 1'b0);

        // reset in the middle of a stream
        for (int i = 0; i < 4; i++) begin
            nxt();
            drive(1'b1, 1'b0, 12'(12'h040 + i), 1'b1, 32'h0, 4'hF, 20'(i));
        end
        nxt();
        rst_n = 1'b0;
        idle();
        #1;
        chk("mrst_vld1", vld1, 1'b0);
        chk("mrst_vld2", vld2, 1'b0);
        chk("mrst_cen", cen1, 1'b1);
        repeat (2) nxt();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nxt();
            chk("post_vld1", vld1, 1'b0);
            chk("post_vld2", vld2, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcdm_bank_ctrl.md
Name: tcdm_bank_ctrl

Overview:
- Memory-side stage directly downstream of the test-and-set bridge, one instance per TCDM bank.
- Accepts the bridge's req/gnt request stream and drives a single-port SRAM macro (active-low controls, bit-write mask).
- Generates the ID-tagged response (r_valid/r_ID/r_aux/r_rdata) back toward the response network after the SRAM read latency.
- Suppresses the response for the set-store phase of a test-and-set, so the initiator sees exactly one response (the old value).

Parameters:
- ADDR_MEM_WIDTH, 12, bank word-address width.
- ID_WIDTH, 20, request/response ID width.
- DATA_WIDTH, 32, data width.
- AUX_WIDTH, 2, sideband width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- MEM_LATENCY, 1, SRAM read latency in cycles; legal values 1 or 2, any other value is an elaboration error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- data_req_i  in  1  request from the bridge.
- data_ts_set_i  in  1  request is the T&S set-store phase.
- data_add_i  in  ADDR_MEM_WIDTH  word address.
- data_wen_i  in  1  1 = load, 0 = store.
- data_wdata_i  in  DATA_WIDTH  write data.
- data_be_i  in  BE_WIDTH  byte enables.
- data_ID_i  in  ID_WIDTH  request ID.
- data_aux_i  in  AUX_WIDTH  sideband.
- data_gnt_o  out  1  grant to the bridge.
- bank_stall_i  in  1  bank unavailable (power/scrub manager).
- mem_cen_o  out  1  SRAM chip enable, active low.
- mem_wen_o  out  1  SRAM write enable, active low.
- mem_addr_o  out  ADDR_MEM_WIDTH  SRAM address.
- mem_wdata_o  out  DATA_WIDTH  SRAM write data.
- mem_bwen_o  out  DATA_WIDTH  SRAM bit-write mask, active low.
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid MEM_LATENCY cycles after the access.
- r_valid_o  out  1  response valid.
- r_ID_o  out  ID_WIDTH  response ID.
- r_aux_o  out  AUX_WIDTH  response sideband.
- r_rdata_o  out  DATA_WIDTH  response data.

Behaviour:
- Reset: clk rising edge; rst_n asynchronous, active-low. All pipeline registers clear, so r_valid_o=0, r_ID_o=0, r_aux_o=0, r_rdata_o=0.
- Grant rule (combinational): data_gnt_o = data_req_i & (~bank_stall_i | data_ts_set_i).
  - Stall is ignored for the set phase. The set store therefore always lands the cycle after the granted test read, which keeps T&S atomic.
- Access: fire = data_gnt_o.
  - mem_cen_o = ~fire.
  - mem_wen_o = ~(fire & ~data_wen_i).
  - mem_addr_o, mem_wdata_o pass through.
  - mem_bwen_o[8*i+:8] = {8{~data_be_i[i]}}; all ones when the request is a load.
  - No access without a grant; the SRAM is never enabled while stalled.
- Response pipeline: shift register of depth MEM_LATENCY. Each stage holds valid, ID, aux and is_load. Stage 0 loads on every clock.
  - valid = fire & ~data_ts_set_i.
  - Loads and ordinary stores both produce a response; the set phase produces none.
- Response output: taken from the last stage.
  - r_valid_o = stage valid.
  - r_ID_o / r_aux_o = stage fields, zero when not valid.
  - r_rdata_o = mem_rdata_i if stage valid & is_load, else 0.
  - Latency from the grant cycle: exactly MEM_LATENCY cycles. Throughput: one access per cycle; back-to-back grants produce back-to-back responses in order.
- No response backpressure; the response network must always accept.
- Simultaneous events:
  - Stall and set phase together: the set phase is granted.
  - Stall rising while a normal request is held: gnt=0, the request stays pending, and it is granted on the first cycle stall=0.
  - Stall during pipeline drain: already-granted responses still emerge.
- Reset mid-operation: in-flight responses are dropped, no spurious r_valid_o afterwards, and the SRAM is disabled while rst_n=0 because no grant is possible with req inputs gated low by the bridge reset.
- T&S sequence as seen here:
  - Cycle N: load, ts_set=0 → response with the old data at N+MEM_LATENCY.
  - Cycle N+1: store of all ones with the captured BE, ts_set=1 → SRAM write, no response.

Test Plan:
- MEM_LATENCY=1: store 0xDEADBEEF to addr 0x10 with be=4'hF, ID=5, then load addr 0x10 with ID=7 → store response (ID 5, rdata 0) one cycle after its grant; load response ID 7, rdata 0xDEADBEEF one cycle after its grant.
- Partial write: store 0x11223344 with be=4'b0101 → mem_bwen_o=0xFF00FF00 and mem_wen_o=0; a later read returns the merged word.
- T&S with MEM_LATENCY=2: location holds 0 → exactly one response, rdata 0 two cycles after the test read. The set cycle shows cen=0, wen=0, wdata=0xFFFFFFFF, and no r_valid for it. A follow-up load returns 0xFFFFFFFF.
- bank_stall_i=1 for 3 cycles with a load pending → gnt=0 and cen=1 during the stall. Grant on the first cycle after stall drops; response MEM_LATENCY cycles later with the correct ID.
- Stall asserted in the set-phase cycle → set granted anyway and the SRAM write occurs.
- 8 back-to-back loads IDs 0..7 → 8 consecutive r_valid cycles in order. Assert rst_n=0 mid-stream → r_valid_o=0 immediately, and no residual responses after release.
